// File: rtl/uart_event_framer_if.sv
// uart_event_framer_if
//   Groups the byte-input, event-output, pulse and statistics signals of
//   uart_event_framer into one bundle.
//   Optional macro: UART_EVENT_FRAMER_TIMESTAMP_EN adds TS_BITS and ev_ts.
// Modports:
//   master : the surrounding system (drives rx_*, ev_ready, clr_stats)
//   slave  : the framer (drives ev_*, ping, frame_timeout, counters, level)
interface uart_event_framer_if #(
  parameter int unsigned X_BITS     = 7,
  parameter int unsigned Y_BITS     = 7,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_BITS   = 16
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  , parameter int unsigned TS_BITS  = 16
`endif
);
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic                          ev_valid;
  logic                          ev_ready;
  logic [X_BITS-1:0]             ev_x;
  logic [Y_BITS-1:0]             ev_y;
  logic                          ev_pol;
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  logic [TS_BITS-1:0]            ev_ts;
`endif
  logic                          ping;
  logic                          frame_timeout;
  logic                          clr_stats;
  logic [CNT_BITS-1:0]           cksum_err_cnt;
  logic [CNT_BITS-1:0]           drop_cnt;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output rx_data, rx_valid, ev_ready, clr_stats,
    input  ev_valid, ev_x, ev_y, ev_pol,
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
    input  ev_ts,
`endif
    input  ping, frame_timeout, cksum_err_cnt, drop_cnt, fifo_level
  );

  modport slave (
    input  rx_data, rx_valid, ev_ready, clr_stats,
    output ev_valid, ev_x, ev_y, ev_pol,
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
    output ev_ts,
`endif
    output ping, frame_timeout, cksum_err_cnt, drop_cnt, fifo_level
  );
endinterface

// File: rtl/uart_event_framer.sv
// uart_event_framer
//   Frames a uart_rx byte stream into 4-byte checksummed event packets
//   (x, y, flags, x^y^flags), resynchronises on an inter-byte timeout,
//   recognises a ping byte at packet start, and queues events in a
//   show-ahead FIFO with a valid/ready output. Keeps saturating counters
//   of checksum errors and FIFO-full drops.
//   Optional macro: UART_EVENT_FRAMER_TIMESTAMP_EN adds a free-running
//   timestamp captured on the checksum byte and carried with each event.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   io_bus : uart_event_framer_if.slave (rx byte in, event out, pulses, stats)
module uart_event_framer #(
  parameter int unsigned X_BITS         = 7,
  parameter int unsigned Y_BITS         = 7,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter logic [7:0]  PING_BYTE      = 8'hFF,
  parameter int unsigned CNT_BITS       = 16
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  , parameter int unsigned TS_BITS      = 16
`endif
) (
  input logic                clk,
  input logic                rst_n,
  uart_event_framer_if.slave io_bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  localparam int unsigned EW = TS_BITS + 1 + Y_BITS + X_BITS;
`else
  localparam int unsigned EW = 1 + Y_BITS + X_BITS;
`endif

  localparam logic [1:0] StB0 = 2'd0;
  localparam logic [1:0] StB1 = 2'd1;
  localparam logic [1:0] StB2 = 2'd2;
  localparam logic [1:0] StB3 = 2'd3;

  localparam logic [CNT_BITS-1:0] CntMax = '1;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [7:0]          r_b0;
  logic [7:0]          r_b1;
  logic [7:0]          r_b2;
  logic [TW-1:0]       r_tmo_cnt;
  logic                r_ping;
  logic [CNT_BITS-1:0] r_cksum_cnt;
  logic [CNT_BITS-1:0] r_drop_cnt;
  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_level;
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  logic [TS_BITS-1:0]  r_ts;
`endif

  logic          w_tmo;
  logic          w_at_b0;
  logic          w_is_ping;
  logic          w_b3;
  logic          w_ck_ok;
  logic          w_push;
  logic          w_cksum_err;
  logic          w_pop;
  logic          w_full;
  logic          w_accept;
  logic          w_drop;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  // Partial packet abandoned once the idle count reaches the limit.
  assign w_tmo     = (r_state != StB0) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));
  // A byte arriving in the timeout cycle starts a fresh packet.
  assign w_at_b0   = (r_state == StB0) || w_tmo;
  assign w_is_ping = io_bus.rx_data == PING_BYTE;
  assign w_b3      = io_bus.rx_valid && !w_at_b0 && (r_state == StB3);
  assign w_ck_ok   = (r_b0 ^ r_b1 ^ r_b2) == io_bus.rx_data;
  assign w_push      = w_b3 && w_ck_ok;
  assign w_cksum_err = w_b3 && !w_ck_ok;

  assign w_pop    = (r_level != '0) && io_bus.ev_ready;
  assign w_full   = r_level == (AW + 1)'(FIFO_DEPTH);
  // A same-cycle pop frees the slot the push needs.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  assign w_entry = {r_ts, r_b2[0], r_b1[Y_BITS-1:0], r_b0[X_BITS-1:0]};
`else
  assign w_entry = {r_b2[0], r_b1[Y_BITS-1:0], r_b0[X_BITS-1:0]};
`endif

  always_comb begin
    w_next_state = w_tmo ? StB0 : r_state;
    if (io_bus.rx_valid) begin
      if (w_at_b0) begin
        w_next_state = w_is_ping ? StB0 : StB1;
      end else begin
        unique case (r_state)
          StB1:    w_next_state = StB2;
          StB2:    w_next_state = StB3;
          default: w_next_state = StB0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StB0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_tmo_cnt   <= '0;
      r_ping      <= 1'b0;
      r_cksum_cnt <= '0;
      r_drop_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      r_state <= w_next_state;
      r_ping  <= io_bus.rx_valid && w_at_b0 && w_is_ping;

      if (io_bus.rx_valid || w_at_b0) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end

      if (io_bus.rx_valid) begin
        if (w_at_b0) begin
          if (!w_is_ping) r_b0 <= io_bus.rx_data;
        end else if (r_state == StB1) begin
          r_b1 <= io_bus.rx_data;
        end else if (r_state == StB2) begin
          r_b2 <= io_bus.rx_data;
        end
      end

      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept && !w_pop) begin
        r_level <= r_level + (AW + 1)'(1);
      end else if (!w_accept && w_pop) begin
        r_level <= r_level - (AW + 1)'(1);
      end

      // Clear takes priority over a same-cycle increment.
      if (io_bus.clr_stats) begin
        r_cksum_cnt <= '0;
        r_drop_cnt  <= '0;
      end else begin
        if (w_cksum_err && (r_cksum_cnt != CntMax)) r_cksum_cnt <= r_cksum_cnt + CNT_BITS'(1);
        if (w_drop && (r_drop_cnt != CntMax))       r_drop_cnt  <= r_drop_cnt + CNT_BITS'(1);
      end
    end
  end

`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_BITS'(1);
  end
`endif

  // Storage needs no reset: entries are only visible while r_level covers them.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  assign io_bus.ev_valid      = r_level != '0;
  assign io_bus.ev_x          = io_bus.ev_valid ? w_head[X_BITS-1:0] : '0;
  assign io_bus.ev_y          = io_bus.ev_valid ? w_head[X_BITS +: Y_BITS] : '0;
  assign io_bus.ev_pol        = io_bus.ev_valid && w_head[X_BITS+Y_BITS];
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  assign io_bus.ev_ts         = io_bus.ev_valid ? w_head[EW-1 -: TS_BITS] : '0;
`endif
  assign io_bus.ping          = r_ping;
  assign io_bus.frame_timeout = w_tmo;
  assign io_bus.cksum_err_cnt = r_cksum_cnt;
  assign io_bus.drop_cnt      = r_drop_cnt;
  assign io_bus.fifo_level    = r_level;
endmodule

// File: tb/tb_uart_event_framer.sv
// tb_uart_event_framer
//   Self-checking bench for uart_event_framer: directed scenarios plus a
//   randomized byte stream, all compared every cycle against a queue-based
//   packet/FIFO reference model.
module tb_uart_event_framer;
  localparam int unsigned XB    = 7;
  localparam int unsigned YB    = 7;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 2048;
  localparam int unsigned CNT   = 4;
  localparam logic [7:0]  PING  = 8'hFF;
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
  localparam int unsigned TSB   = 16;
`endif
  localparam int CNT_MAX = (1 << CNT) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_event_framer_if #(
    .X_BITS(XB), .Y_BITS(YB), .FIFO_DEPTH(DEPTH), .CNT_BITS(CNT)
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
    , .TS_BITS(TSB)
`endif
  ) u_if ();

  uart_event_framer #(
    .X_BITS(XB), .Y_BITS(YB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO),
    .PING_BYTE(PING), .CNT_BITS(CNT)
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
    , .TS_BITS(TSB)
`endif
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a packet is whatever bytes have arrived since the last
  // packet boundary; events live in a plain queue.
  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        pol;
    logic [31:0] ts;
  } ev_t;

  ev_t        m_q[$];
  logic [7:0] m_part[$];
  int         m_err = 0;
  int         m_drop = 0;
  bit         m_ping = 0;
  longint     cyc = 0;
  longint     last_cyc = 0;
  int         m_ts = 0;

  function automatic bit model_tmo();
    return (m_part.size() != 0) && ((cyc - last_cyc) > longint'(TMO));
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [7:0] d,
                            input bit rdy, input bit clr);
    bit  tmo;
    ev_t e;
    tmo = model_tmo();
    cyc++;
    if (!rst) begin
      m_q.delete();
      m_part.delete();
      m_err = 0;
      m_drop = 0;
      m_ping = 0;
      m_ts = 0;
      return;
    end
    m_ping = 0;
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (tmo) m_part.delete();
    if (v) begin
      last_cyc = cyc - 1;
      if (m_part.size() == 0 && d == PING) begin
        m_ping = 1;
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          if ((m_part[0] ^ m_part[1] ^ m_part[2]) == m_part[3]) begin
            e.x   = m_part[0] & 8'((1 << XB) - 1);
            e.y   = m_part[1] & 8'((1 << YB) - 1);
            e.pol = m_part[2][0];
            e.ts  = m_ts;
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else if (m_drop < CNT_MAX) m_drop++;
          end else if (m_err < CNT_MAX) begin
            m_err++;
          end
          m_part.delete();
        end
      end
    end
    if (clr) begin
      m_err = 0;
      m_drop = 0;
    end
    m_ts++;
  endtask

  task automatic check_all();
    check_eq("ev_valid", 64'(u_if.ev_valid), 64'(m_q.size() != 0));
    check_eq("fifo_level", 64'(u_if.fifo_level), 64'(m_q.size()));
    check_eq("ping", 64'(u_if.ping), 64'(m_ping));
    check_eq("frame_timeout", 64'(u_if.frame_timeout), 64'(model_tmo()));
    check_eq("cksum_err_cnt", 64'(u_if.cksum_err_cnt), 64'(m_err));
    check_eq("drop_cnt", 64'(u_if.drop_cnt), 64'(m_drop));
    if (m_q.size() != 0) begin
      check_eq("ev_x", 64'(u_if.ev_x), 64'(m_q[0].x));
      check_eq("ev_y", 64'(u_if.ev_y), 64'(m_q[0].y));
      check_eq("ev_pol", 64'(u_if.ev_pol), 64'(m_q[0].pol));
`ifdef UART_EVENT_FRAMER_TIMESTAMP_EN
      check_eq("ev_ts", 64'(u_if.ev_ts), 64'(m_q[0].ts[TSB-1:0]));
`endif
    end
  endtask

  // One clock: drive this cycle's byte, step the model at the edge, check after.
  task automatic tick(input bit v, input logic [7:0] d);
    u_if.rx_valid = v;
    u_if.rx_data  = d;
    @(posedge clk);
    model_step(rst_n, v, d, u_if.ev_ready, u_if.clr_stats);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    tick(1'b1, b0);
    tick(1'b1, b1);
    tick(1'b1, b2);
    tick(1'b1, b3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  logic [7:0] pend[$];

  task automatic gen_packet();
    int unsigned k;
    logic [7:0]  a, b, c;
    k = $urandom_range(0, 19);
    a = 8'($urandom_range(0, 254));
    b = 8'($urandom);
    c = 8'($urandom);
    if (k < 12) begin
      pend.push_back(a); pend.push_back(b); pend.push_back(c); pend.push_back(a ^ b ^ c);
    end else if (k < 15) begin
      pend.push_back(a); pend.push_back(b); pend.push_back(c);
      pend.push_back(a ^ b ^ c ^ 8'(1 << $urandom_range(0, 7)));
    end else if (k < 18) begin
      pend.push_back(PING);
    end else begin
      pend.push_back(8'($urandom));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int found;
    u_if.rx_valid  = 1'b0;
    u_if.rx_data   = 8'h00;
    u_if.ev_ready  = 1'b1;
    u_if.clr_stats = 1'b0;
    #1;

    // Reset state
    rst_n = 1'b0;
    idle(2);
    check_eq("rst ev_valid", 64'(u_if.ev_valid), 64'd0);
    check_eq("rst fifo_level", 64'(u_if.fifo_level), 64'd0);
    check_eq("rst ping", 64'(u_if.ping), 64'd0);
    check_eq("rst cksum", 64'(u_if.cksum_err_cnt), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Valid packet, visible one cycle after the checksum strobe
    send(8'h12, 8'h34, 8'h01, 8'h27);
    check_eq("pkt valid", 64'(u_if.ev_valid), 64'd1);
    check_eq("pkt x", 64'(u_if.ev_x), 64'h12);
    check_eq("pkt y", 64'(u_if.ev_y), 64'h34);
    check_eq("pkt pol", 64'(u_if.ev_pol), 64'd1);
    idle(1);
    check_eq("pkt drained", 64'(u_if.fifo_level), 64'd0);

    // Bad checksum, then resync proven by a following good packet
    send(8'h12, 8'h34, 8'h01, 8'h00);
    check_eq("bad valid", 64'(u_if.ev_valid), 64'd0);
    check_eq("bad cnt", 64'(u_if.cksum_err_cnt), 64'd1);
    send(8'h55, 8'h66, 8'h00, 8'h33);
    check_eq("resync x", 64'(u_if.ev_x), 64'h55);
    idle(2);

    // Ping at packet start
    tick(1'b1, PING);
    check_eq("ping pulse", 64'(u_if.ping), 64'd1);
    check_eq("ping level", 64'(u_if.fifo_level), 64'd0);
    idle(1);
    check_eq("ping end", 64'(u_if.ping), 64'd0);

    // Timeout: pulse on the cycle after TMO idle cycles
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h34);
    found = 0;
    for (int k = 1; k <= TMO + 10; k++) begin
      if (u_if.frame_timeout) begin
        found = k;
        break;
      end
      tick(1'b0, 8'h00);
    end
    check_eq("timeout cycle", 64'(found), 64'(TMO + 1));
    idle(1);
    send(8'h05, 8'h06, 8'h00, 8'h03);
    check_eq("post-tmo x", 64'(u_if.ev_x), 64'h05);
    check_eq("post-tmo y", 64'(u_if.ev_y), 64'h06);
    check_eq("post-tmo pol", 64'(u_if.ev_pol), 64'd0);
    idle(2);

    // Byte arriving in the timeout cycle starts a new packet
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h34);
    idle(TMO);
    check_eq("tmo coincide pulse", 64'(u_if.frame_timeout), 64'd1);
    send(8'h21, 8'h22, 8'h01, 8'h02);
    check_eq("tmo coincide x", 64'(u_if.ev_x), 64'h21);
    idle(2);

    // Backpressure: 17 packets into a 16-deep FIFO
    u_if.ev_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 8'(i + 32), 8'(i & 1), 8'(i) ^ 8'(i + 32) ^ 8'(i & 1));
    end
    check_eq("full level", 64'(u_if.fifo_level), 64'd16);
    check_eq("full drop", 64'(u_if.drop_cnt), 64'd1);
    check_eq("full head", 64'(u_if.ev_x), 64'd0);
    // Push into a full FIFO while popping: accepted, no drop
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h31);
    tick(1'b1, 8'h01);
    u_if.ev_ready = 1'b1;
    tick(1'b1, 8'h11 ^ 8'h31 ^ 8'h01);
    u_if.ev_ready = 1'b0;
    check_eq("pp drop", 64'(u_if.drop_cnt), 64'd1);
    check_eq("pp level", 64'(u_if.fifo_level), 64'd16);
    u_if.ev_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check_eq("drain order", 64'(u_if.ev_x), (i == 16) ? 64'h11 : 64'(i));
      tick(1'b0, 8'h00);
    end
    check_eq("drain empty", 64'(u_if.ev_valid), 64'd0);

    // Counter saturation and clear priority
    for (int i = 0; i < 20; i++) send(8'(i), 8'h40, 8'h00, 8'(i) ^ 8'h41);
    check_eq("sat cksum", 64'(u_if.cksum_err_cnt), 64'(CNT_MAX));
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h04);
    u_if.clr_stats = 1'b1;
    tick(1'b1, 8'h00);
    u_if.clr_stats = 1'b0;
    check_eq("clr cksum", 64'(u_if.cksum_err_cnt), 64'd0);
    check_eq("clr drop", 64'(u_if.drop_cnt), 64'd0);

    // Reset mid-packet with events queued
    u_if.ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i + 7), 8'h09, 8'h01, 8'(i + 7) ^ 8'h08);
    tick(1'b1, 8'h44);
    tick(1'b1, 8'h45);
    rst_n = 1'b0;
    tick(1'b0, 8'h00);
    rst_n = 1'b1;
    check_eq("mrst level", 64'(u_if.fifo_level), 64'd0);
    check_eq("mrst valid", 64'(u_if.ev_valid), 64'd0);
    idle(4);
    u_if.ev_ready = 1'b1;
    send(8'h0A, 8'h0B, 8'h01, 8'h00);
    check_eq("mrst pkt x", 64'(u_if.ev_x), 64'h0A);
    check_eq("mrst pkt y", 64'(u_if.ev_y), 64'h0B);
    idle(2);

    // Randomized stream against the model
    for (int c = 0; c < 6000; c++) begin
      if (pend.size() == 0) gen_packet();
      u_if.ev_ready  = ($urandom_range(0, 9) < 6);
      u_if.clr_stats = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0) tick(1'b1, pend.pop_front());
      else tick(1'b0, 8'h00);
    end
    u_if.clr_stats = 1'b0;
    u_if.ev_ready  = 1'b1;
    idle(DEPTH + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
